// File: rtl/bcd_ascii_tx_pkg.sv
// Shared encodings for the BCD-to-ASCII transmitter: FSM states, ASCII constants
// and a digit extraction helper for the packed 40-bit digit register.
package bcd_ascii_tx_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SCAN = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_TERM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_BAD  = 8'h3F;
    localparam logic [3:0] TOP_IDX    = 4'd9;

    // Index is widened before scaling so that digit 9 (bit 36) does not wrap.
    function automatic logic [3:0] digit_at(input logic [39:0] d, input logic [3:0] i);
        return d[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bcd_ascii_tx_digit.sv
// Combinational map of one BCD digit to its ASCII character; non-decimal
// codes 10..15 become '?' so a corrupt digit is visible on the line.
module bcd_digit_ascii
    import bcd_ascii_tx_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        if (digit <= 4'd9) ascii = ASCII_ZERO + {4'h0, digit};
        else               ascii = ASCII_BAD;
    end

endmodule

// File: rtl/bcd_ascii_tx.sv
// Serialises a captured 10-digit BCD value as ASCII bytes (MSD first, optional
// leading-zero suppression) followed by a terminator, over a valid/ready link.
module bcd_ascii_tx
    import bcd_ascii_tx_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR      = 8'h0A,
    parameter bit         SUPPRESS_ZEROS = 1'b1
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd4,
    input  logic [3:0] bcd5,
    input  logic [3:0] bcd6,
    input  logic [3:0] bcd7,
    input  logic [3:0] bcd8,
    input  logic [3:0] bcd9,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    logic [2:0]  state;
    logic [3:0]  idx;
    logic [39:0] digits;
    logic [3:0]  sel_idx;
    logic [7:0]  sel_ascii;
    logic        scan_skip;

    assign scan_skip = SUPPRESS_ZEROS && (idx != 4'd0) && (digit_at(digits, idx) == 4'd0);

    // In SEND the registered byte must be the one after the current beat.
    assign sel_idx = (state == ST_SEND && idx != 4'd0) ? idx - 4'd1 : idx;

    bcd_digit_ascii u_digit (
        .digit (digit_at(digits, sel_idx)),
        .ascii (sel_ascii)
    );

    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && start)
            digits <= {bcd9, bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_IDLE;
            idx      <= TOP_IDX;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= TOP_IDX;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_skip) begin
                        idx <= idx - 4'd1;
                    end else begin
                        tx_data  <= sel_ascii;
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (idx != 4'd0) begin
                            idx     <= idx - 4'd1;
                            tx_data <= sel_ascii;
                        end else begin
                            tx_data <= TERM_CHAR;
                            state   <= ST_TERM;
                        end
                    end
                end
                ST_TERM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/bcd_ascii_tx.md
BCD_ASCII_TX -- requirements
Module: bcd_ascii_tx

Interface
REQ-001 Parameter TERM_CHAR, default 8'h0A, terminator byte sent after the last digit.
REQ-002 Parameter SUPPRESS_ZEROS, default 1, 1 = drop leading zero digits.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to capture and transmit bcd0..bcd9; driven by the upstream converter's fin.
REQ-006 bcd0..bcd9  input  4 each  BCD digits, bcd0 least significant, bcd9 most significant.
REQ-007 tx_data  output  8  ASCII byte currently offered.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  sink accepts; a beat transfers on a cycle with tx_valid=1 and tx_ready=1.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the terminator beat transfers.

Function
REQ-012 The block SHALL implement states IDLE, SCAN, SEND, TERM, DONE.
REQ-013 In IDLE with start=1, the block SHALL capture all ten digits into a 40-bit register, set digit index to 9, and enter SCAN the next cycle.
REQ-014 start in any state other than IDLE SHALL be ignored, with no change to captured digits.
REQ-015 In SCAN with SUPPRESS_ZEROS=1, while index>0 and digit[index]==0, the block SHALL decrement index, one digit per cycle.
REQ-016 SCAN SHALL enter SEND once that condition is false, so index 0 is always sent and value 0 yields a single '0'.
REQ-017 With SUPPRESS_ZEROS=0, SCAN SHALL last exactly one cycle with index 9.
REQ-018 In SEND, tx_valid SHALL be 1 and tx_data SHALL be 8'h30+digit[index] for digits 0..9, and 8'h3F ('?') for digits 10..15.
REQ-019 On a SEND handshake, the block SHALL decrement index if index>0, else enter TERM.
REQ-020 In TERM, tx_valid SHALL be 1 and tx_data SHALL be TERM_CHAR; on handshake the block SHALL enter DONE.
REQ-021 DONE SHALL last one cycle with done=1 and tx_valid=0, then return to IDLE.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable and tx_valid SHALL NOT drop.
REQ-023 tx_valid SHALL be 0 in IDLE, SCAN and DONE; tx_ready SHALL be ignored in those states.
REQ-024 tx_data SHALL be a registered output.
REQ-025 The first byte SHALL appear 2+k cycles after the start cycle, where k is the number of suppressed zeros (0..9); each accepted beat advances one byte per cycle when tx_ready is held high.
REQ-026 A frame SHALL be 2..11 bytes (digits plus terminator), with no gaps when tx_ready is held high.

Reset
REQ-027 With RST=0 at a clock edge, the block SHALL enter IDLE, with index=9, tx_valid=0, tx_data=8'h00, busy=0 and done=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without emitting the terminator; tx_valid SHALL be 0 from the following cycle.
REQ-029 The captured digit register SHALL NOT require a reset value.

Structure
REQ-030 A shared package SHALL hold the state encoding, ASCII_ZERO=8'h30 and ASCII_BAD=8'h3F.
REQ-031 The digit-to-ASCII mapping SHALL be a sub-module, bcd_digit_ascii (4-bit in, 8-bit out, combinational).

Verification
REQ-032 All digits 0, SUPPRESS_ZEROS=1, tx_ready=1 -> bytes 0x30, 0x0A, then a done pulse one cycle after the 0x0A beat.
REQ-033 Digits of 4294967295, tx_ready=1 -> 11 consecutive bytes 0x34,0x32,0x39,0x34,0x39,0x36,0x37,0x32,0x39,0x35,0x0A, with the first byte 2 cycles after start.
REQ-034 Digits of 1203 with tx_ready alternating 1/0 -> bytes 0x31,0x32,0x30,0x33,0x0A, with tx_data stable across every stall cycle.
REQ-035 SUPPRESS_ZEROS=0, digits of 7 -> nine 0x30 bytes, then 0x37, then 0x0A.
REQ-036 bcd0=4'hA, others 0 -> 0x3F, 0x0A; start pulsed in mid-frame -> ignored, output unchanged.
REQ-037 RST low after the second beat of 4294967295 -> tx_valid=0 next cycle, busy=0; a new start then produces a complete fresh frame.
